// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the convolution tile sequencer.
package conv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CRST,
    S_WL0,
    S_WLD,
    S_AL0,
    S_EXE,
    S_DRN,
    S_ACC,
    S_DONE
  } state_t;

  localparam int INST_W = 35;
  localparam int ADDR_W = 11;

  // Bit positions inside the 35-bit core instruction word
  localparam int B_MODE     = 34;
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LO    = 20;  // A_pmem occupies [30:20]
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_LO    = 7;   // A_xmem occupies [17:7]
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // Both memories disabled and in read mode, every strobe low
  localparam logic [INST_W-1:0] IDLE_WORD =
    (35'd1 << B_CEN_P) | (35'd1 << B_WEN_P) |
    (35'd1 << B_CEN_X) | (35'd1 << B_WEN_X);

endpackage

// File: rtl/acc_addr_gen.sv
// Pmem address of partial sum k contributing to output pixel o.
module acc_addr_gen #(
  parameter int LEN_NIJ = 36,
  parameter int IN_W    = 6,
  parameter int OUT_W   = 4
) (
  input  logic [3:0]  i_o,
  input  logic [3:0]  i_k,
  output logic [10:0] o_addr
);

  logic [10:0] w_base;
  logic [10:0] w_row;
  logic [10:0] w_col;

  // kij block base plus the input pixel this kernel tap sees (3x3 kernel)
  always_comb begin
    w_base = 11'(i_k) * 11'(LEN_NIJ);
    w_row  = 11'(i_o / 4'(OUT_W)) + 11'(i_k / 4'd3);
    w_col  = 11'(i_o % 4'(OUT_W)) + 11'(i_k % 4'd3);
    o_addr = w_base + w_row * 11'(IN_W) + w_col;
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer driving the core instruction word through one full 3x3 conv tile.
module conv_seq_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int LEN_KIJ  = 9,
  parameter int LEN_NIJ  = 36,
  parameter int IN_W     = 6,
  parameter int OUT_W    = 4,
  parameter int W_BASE   = 1024,
  parameter int W_STRIDE = 16,
  parameter int RST_CYC  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_in,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              core_reset,
  output logic              busy,
  output logic              out_valid,
  output logic [3:0]        out_idx,
  output logic              done
);

  localparam logic [6:0]  C_RST      = 7'(RST_CYC);
  localparam logic [6:0]  C_COL      = 7'(COL);
  localparam logic [6:0]  C_NIJ      = 7'(LEN_NIJ);
  localparam logic [6:0]  C_EXE      = 7'(LEN_NIJ + ROW + COL);
  localparam logic [6:0]  C_KIJ      = 7'(LEN_KIJ);
  localparam logic [5:0]  C_NIJ6     = 6'(LEN_NIJ);
  localparam logic [3:0]  C_KIJ_LAST = 4'(LEN_KIJ - 1);
  localparam logic [3:0]  C_O_LAST   = 4'(OUT_W * OUT_W - 1);
  localparam logic [10:0] A_WBASE    = 11'(W_BASE);
  localparam logic [10:0] A_WSTR     = 11'(W_STRIDE);
  localparam logic [10:0] A_NIJ      = 11'(LEN_NIJ);

  state_t            r_state, w_state_nxt;
  logic [6:0]        r_cnt, w_cnt_nxt;
  logic [3:0]        r_kij, w_kij_nxt;
  logic [3:0]        r_o, w_o_nxt;
  logic [5:0]        r_n, w_n_nxt;
  logic              r_wpend, w_wpend_nxt;
  logic              r_mode, w_mode_nxt;
  logic [INST_W-1:0] w_inst;
  logic              w_crst, w_oval, w_done;
  logic [3:0]        w_k;
  logic [10:0]       w_acc_addr;

  // In ACC the read for tap k happens at phase count k+1
  assign w_k = 4'(r_cnt - 7'd1);

  acc_addr_gen #(
    .LEN_NIJ (LEN_NIJ),
    .IN_W    (IN_W),
    .OUT_W   (OUT_W)
  ) u_acc_addr (
    .i_o    (r_o),
    .i_k    (w_k),
    .o_addr (w_acc_addr)
  );

  // FSM state, phase counters and latched run mode
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_kij   <= '0;
      r_o     <= '0;
      r_n     <= '0;
      r_wpend <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_kij   <= w_kij_nxt;
      r_o     <= w_o_nxt;
      r_n     <= w_n_nxt;
      r_wpend <= w_wpend_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  // Next-state and instruction decode; every phase ends in one gap cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 7'd1;
    w_kij_nxt   = r_kij;
    w_o_nxt     = r_o;
    w_n_nxt     = r_n;
    w_wpend_nxt = 1'b0;
    w_mode_nxt  = r_mode;
    w_inst      = IDLE_WORD;
    w_crst      = 1'b0;
    w_oval      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (start) begin
          w_mode_nxt  = mode_in;
          w_kij_nxt   = '0;
          w_state_nxt = S_CRST;
        end
      end
      S_CRST: begin
        w_crst = (r_cnt < C_RST);
        if (r_cnt == C_RST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WL0;
        end
      end
      S_WL0: begin
        if (r_cnt < C_COL) begin
          w_inst[B_CEN_X]              = 1'b0;
          w_inst[B_L0_WR]              = 1'b1;
          w_inst[B_AX_LO +: ADDR_W]    = A_WBASE + 11'(r_kij) * A_WSTR + 11'(r_cnt);
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WLD;
        end
      end
      S_WLD: begin
        if (r_cnt <= C_COL) begin
          w_inst[B_L0_RD] = 1'b1;
          w_inst[B_LOAD]  = (r_cnt != 7'd0);
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_AL0;
        end
      end
      S_AL0: begin
        if (r_cnt < C_NIJ) begin
          w_inst[B_CEN_X]           = 1'b0;
          w_inst[B_L0_WR]           = 1'b1;
          w_inst[B_AX_LO +: ADDR_W] = 11'(r_cnt);
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_EXE;
        end
      end
      S_EXE: begin
        if (r_cnt <= C_EXE) begin
          w_inst[B_L0_RD] = 1'b1;
          w_inst[B_EXEC]  = (r_cnt != 7'd0);
        end else begin
          w_cnt_nxt   = '0;
          w_n_nxt     = '0;
          w_state_nxt = S_DRN;
        end
      end
      S_DRN: begin
        // Write lags its OFIFO read by one cycle; r_n already counts that read
        if (r_wpend) begin
          w_inst[B_CEN_P]           = 1'b0;
          w_inst[B_WEN_P]           = 1'b0;
          w_inst[B_AP_LO +: ADDR_W] = 11'(r_kij) * A_NIJ + 11'(r_n) - 11'd1;
        end
        if (r_n < C_NIJ6) begin
          if (ofifo_valid) begin
            w_inst[B_OFIFO_RD] = 1'b1;
            w_n_nxt            = r_n + 6'd1;
            w_wpend_nxt        = 1'b1;
          end
        end else begin
          w_n_nxt   = '0;
          w_cnt_nxt = '0;
          if (r_kij == C_KIJ_LAST) begin
            w_o_nxt     = '0;
            w_state_nxt = S_ACC;
          end else begin
            w_kij_nxt   = r_kij + 4'd1;
            w_state_nxt = S_CRST;
          end
        end
      end
      S_ACC: begin
        if (r_cnt == 7'd0) w_crst = 1'b1;
        if (r_cnt >= 7'd1 && r_cnt <= C_KIJ) begin
          w_inst[B_CEN_P]           = 1'b0;
          w_inst[B_AP_LO +: ADDR_W] = w_acc_addr;
        end
        if (r_cnt >= 7'd2 && r_cnt <= C_KIJ + 7'd1) w_inst[B_ACC] = 1'b1;
        if (r_cnt == C_KIJ + 7'd3) begin
          w_oval    = 1'b1;
          w_cnt_nxt = '0;
          w_o_nxt   = r_o + 4'd1;
          if (r_o == C_O_LAST) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
    // Mode bit follows the run so the core sees it from the first busy cycle
    w_inst[B_MODE] = (w_state_nxt != S_IDLE) ? w_mode_nxt : 1'b0;
  end

  // Registered outputs toward the core and host
  always_ff @(posedge clk) begin
    if (reset) begin
      inst       <= IDLE_WORD;
      core_reset <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      done       <= 1'b0;
    end else begin
      inst       <= w_inst;
      core_reset <= w_crst;
      busy       <= (w_state_nxt != S_IDLE);
      out_valid  <= w_oval;
      if (w_oval) out_idx <= r_o;
      done       <= w_done;
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: captures whole runs, then checks each phase.
module tb_conv_seq_ctrl;

  localparam int P_MODE = 34, P_ACC = 33, P_CENP = 32, P_WENP = 31;
  localparam int P_CENX = 19, P_OFRD = 6, P_IFWR = 5, P_IFRD = 4;
  localparam int P_L0RD = 3, P_L0WR = 2, P_EXEC = 1, P_LOAD = 0;
  localparam logic [34:0] IDLE_W = 35'h1800C0000;

  logic        clk = 1'b0;
  logic        reset, start, mode_in, ofifo_valid;
  logic [34:0] inst;
  logic        core_reset, busy, out_valid, done;
  logic [3:0]  out_idx;

  int n_vec = 0;
  int n_err = 0;
  int done_idx;

  logic [34:0] tr_inst[$];
  logic        tr_busy[$], tr_crst[$], tr_oval[$], tr_done[$], tr_ofv[$];
  logic [3:0]  tr_oidx[$];

  conv_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode_in     (mode_in),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .core_reset  (core_reset),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic int pa(input int o, input int k);
    return k * 36 + (o / 4 + k / 3) * 6 + (o % 4 + k % 3);
  endfunction

  // Pulse start, then record every output cycle until done or a cycle budget
  task automatic run_capture(input logic md, input bit do_stall, input bit do_restart);
    int rd_seen, stall_left;
    bit stalled;
    rd_seen = 0; stall_left = 0; stalled = 0; done_idx = -1;
    tr_inst.delete(); tr_busy.delete(); tr_crst.delete(); tr_oval.delete();
    tr_done.delete(); tr_ofv.delete(); tr_oidx.delete();
    ofifo_valid = 1'b1;
    start = 1'b1; mode_in = md;
    @(posedge clk); #1;
    start = 1'b0; mode_in = ~md;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tr_inst.push_back(inst); tr_busy.push_back(busy); tr_crst.push_back(core_reset);
      tr_oval.push_back(out_valid); tr_done.push_back(done); tr_oidx.push_back(out_idx);
      if (inst[P_OFRD] === 1'b1) rd_seen++;
      if (do_stall && !stalled && rd_seen == 82) begin stall_left = 5; stalled = 1; end
      ofifo_valid = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      tr_ofv.push_back(ofifo_valid);
      start = (do_restart && cyc == 300);
      if (done === 1'b1) begin done_idx = cyc; break; end
      @(posedge clk); #1;
    end
    start = 1'b0; ofifo_valid = 1'b1; mode_in = 1'b0;
    n_vec++;
    if (done_idx < 0) begin n_err++; $display("FAIL run_timeout: no done within budget"); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode_in = 1'b0; ofifo_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (inst !== IDLE_W) begin n_err++; $display("FAIL reset_inst got %h want %h", inst, IDLE_W); end
    n_vec++; if ({core_reset, busy, out_valid, done} !== 4'b0) begin n_err++;
      $display("FAIL reset_flags got %b want 0000", {core_reset, busy, out_valid, done}); end
    n_vec++; if (out_idx !== 4'd0) begin n_err++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_busy_len(input int exp_len);
    int bad;
    bad = 0;
    n_vec++; if (done_idx !== exp_len) begin n_err++; $display("FAIL run_length got %0d want %0d", done_idx, exp_len); end
    n_vec++; if (tr_busy[0] !== 1'b1) begin n_err++; $display("FAIL busy_rise got %b want 1", tr_busy[0]); end
    for (int t = 0; t < done_idx; t++) if (tr_busy[t] !== 1'b1) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL busy_hold got %0d low cycles want 0", bad); end
    if (done_idx >= 0) begin
      n_vec++; if (tr_busy[done_idx] !== 1'b0) begin n_err++; $display("FAIL busy_fall got %b want 0", tr_busy[done_idx]); end
    end
  endtask

  task automatic test_weight_load();
    int nw, na, nl, len, ex;
    logic [10:0] a;
    nw = 0; na = 0; nl = 0; len = 0;
    for (int t = 0; t < tr_inst.size(); t++) begin
      a = tr_inst[t][17:7];
      if (tr_inst[t][P_L0WR] === 1'b1 && tr_inst[t][P_CENX] === 1'b0) begin
        if (a >= 11'd1024) begin
          ex = 1024 + (nw / 8) * 16 + (nw % 8);
          n_vec++; if (a !== 11'(ex)) begin n_err++; $display("FAIL wl0_addr[%0d] got %0d want %0d", nw, a, ex); end
          nw++;
        end else begin
          ex = na % 36;
          n_vec++; if (a !== 11'(ex)) begin n_err++; $display("FAIL al0_addr[%0d] got %0d want %0d", na, a, ex); end
          na++;
        end
      end
      if (tr_inst[t][P_LOAD] === 1'b1) len++;
      else if (len > 0) begin
        n_vec++; if (len != 8) begin n_err++; $display("FAIL load_run got %0d want 8", len); end
        nl++; len = 0;
      end
    end
    n_vec++; if (nw != 72) begin n_err++; $display("FAIL wl0_count got %0d want 72", nw); end
    n_vec++; if (na != 324) begin n_err++; $display("FAIL al0_count got %0d want 324", na); end
    n_vec++; if (nl != 9) begin n_err++; $display("FAIL load_runs got %0d want 9", nl); end
  endtask

  task automatic test_exe();
    int runs, len;
    runs = 0; len = 0;
    for (int t = 2; t < tr_inst.size(); t++) begin
      if (tr_inst[t][P_EXEC] === 1'b1) begin
        if (len == 0) begin
          n_vec++;
          if (!(tr_inst[t-1][P_L0RD] === 1'b1 && tr_inst[t-1][P_EXEC] === 1'b0 &&
                tr_inst[t-1][P_LOAD] === 1'b0 && tr_inst[t-2][P_L0RD] === 1'b0)) begin
            n_err++; $display("FAIL exe_preamble got %h/%h want one l0_rd-only cycle", tr_inst[t-2], tr_inst[t-1]);
          end
        end
        len++;
      end else if (len > 0) begin
        n_vec++; if (len != 52) begin n_err++; $display("FAIL exe_run got %0d want 52", len); end
        runs++; len = 0;
      end
    end
    n_vec++; if (runs != 9) begin n_err++; $display("FAIL exe_runs got %0d want 9", runs); end
  endtask

  task automatic test_drain();
    int nw, nr, bad;
    nw = 0; nr = 0; bad = 0;
    for (int t = 1; t < tr_inst.size(); t++) begin
      if (tr_inst[t][P_OFRD] === 1'b1) begin
        nr++;
        if (tr_ofv[t-1] !== 1'b1) bad++;
      end
      if (tr_inst[t][P_CENP] === 1'b0 && tr_inst[t][P_WENP] === 1'b0) begin
        n_vec++; if (tr_inst[t][30:20] !== 11'(nw)) begin n_err++;
          $display("FAIL drn_addr[%0d] got %0d want %0d", nw, tr_inst[t][30:20], nw); end
        if (tr_inst[t-1][P_OFRD] !== 1'b1) bad++;
        nw++;
      end
    end
    n_vec++; if (nw != 324) begin n_err++; $display("FAIL drn_writes got %0d want 324", nw); end
    n_vec++; if (nr != 324) begin n_err++; $display("FAIL drn_reads got %0d want 324", nr); end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL drn_handshake got %0d violations want 0", bad); end
  endtask

  task automatic test_acc();
    int nrd, runs, len, ex;
    int acc0 [9];
    acc0 = '{0, 37, 74, 114, 151, 188, 228, 265, 302};
    nrd = 0; runs = 0; len = 0;
    for (int t = 2; t < tr_inst.size(); t++) begin
      if (tr_inst[t][P_CENP] === 1'b0 && tr_inst[t][P_WENP] === 1'b1) begin
        ex = (nrd < 9) ? acc0[nrd] : (nrd == 135) ? 21 : pa(nrd / 9, nrd % 9);
        n_vec++; if (tr_inst[t][30:20] !== 11'(ex)) begin n_err++;
          $display("FAIL acc_addr[o=%0d k=%0d] got %0d want %0d", nrd / 9, nrd % 9, tr_inst[t][30:20], ex); end
        nrd++;
      end
      if (tr_inst[t][P_ACC] === 1'b1) begin
        if (len == 0) begin
          n_vec++;
          if (!(tr_inst[t-1][P_CENP] === 1'b0 && tr_inst[t-1][P_ACC] === 1'b0 && tr_crst[t-2] === 1'b1)) begin
            n_err++; $display("FAIL acc_start got crst=%b prev=%h want crst then first read", tr_crst[t-2], tr_inst[t-1]);
          end
        end
        len++;
      end else if (len > 0) begin
        n_vec++; if (len != 9) begin n_err++; $display("FAIL acc_run got %0d want 9", len); end
        runs++; len = 0;
      end
    end
    n_vec++; if (nrd != 144) begin n_err++; $display("FAIL acc_reads got %0d want 144", nrd); end
    n_vec++; if (runs != 16) begin n_err++; $display("FAIL acc_runs got %0d want 16", runs); end
  endtask

  task automatic test_outputs(input logic md);
    int nv, nd, last_v, bad_m, bad_f;
    nv = 0; nd = 0; last_v = -1; bad_m = 0; bad_f = 0;
    for (int t = 0; t < tr_inst.size(); t++) begin
      if (tr_oval[t] === 1'b1) begin
        n_vec++; if (tr_oidx[t] !== 4'(nv)) begin n_err++; $display("FAIL out_idx[%0d] got %0d want %0d", nv, tr_oidx[t], nv); end
        nv++; last_v = t;
      end
      if (tr_done[t] === 1'b1) nd++;
      if (tr_busy[t] === 1'b1 && tr_inst[t][P_MODE] !== md) bad_m++;
      if (tr_inst[t][P_IFWR] !== 1'b0 || tr_inst[t][P_IFRD] !== 1'b0) bad_f++;
    end
    n_vec++; if (nv != 16) begin n_err++; $display("FAIL out_valid_count got %0d want 16", nv); end
    n_vec++; if (nd != 1 || last_v >= done_idx) begin n_err++;
      $display("FAIL done_pulse got %0d pulses last_valid=%0d done=%0d want 1 after last", nd, last_v, done_idx); end
    n_vec++; if (bad_m != 0) begin n_err++; $display("FAIL mode_bit got %0d wrong cycles want 0 (mode %b)", bad_m, md); end
    n_vec++; if (bad_f != 0) begin n_err++; $display("FAIL ififo_strobes got %0d set cycles want 0", bad_f); end
    if (done_idx >= 0) begin
      n_vec++; if (tr_inst[done_idx] !== IDLE_W) begin n_err++;
        $display("FAIL done_inst got %h want %h", tr_inst[done_idx], IDLE_W); end
    end
  endtask

  task automatic test_reset_mid_exe();
    bit seen;
    seen = 0;
    ofifo_valid = 1'b1;
    start = 1'b1; mode_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      if (inst[P_EXEC] === 1'b1) seen = 1;
      else begin @(posedge clk); #1; end
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL exe_reach got none want execute within 500 cycles"); end
    repeat (5) @(posedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (inst !== IDLE_W) begin n_err++; $display("FAIL midrst_inst got %h want %h", inst, IDLE_W); end
    n_vec++; if (busy !== 1'b0 || core_reset !== 1'b0) begin n_err++;
      $display("FAIL midrst_flags got busy=%b crst=%b want 0 0", busy, core_reset); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (inst !== IDLE_W || busy !== 1'b0) begin n_err++;
      $display("FAIL midrst_idle got %h busy=%b want idle", inst, busy); end
  endtask

  initial begin
    test_reset();
    run_capture(1'b0, 1'b1, 1'b0);
    test_busy_len(1636);
    test_weight_load();
    test_exe();
    test_drain();
    test_acc();
    test_outputs(1'b0);
    repeat (3) @(posedge clk);
    #1;
    run_capture(1'b1, 1'b0, 1'b1);
    test_busy_len(1631);
    test_outputs(1'b1);
    test_reset_mid_exe();
    run_capture(1'b0, 1'b0, 1'b0);
    test_busy_len(1631);
    test_acc();
    test_outputs(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
